// File: rtl/lcd_frame_sequencer.sv
// LCD frame sequencer: picks the clock/date, set-mode or message frame and
// presents it to the LCD character driver. The output changes only on a
// periodic refresh tick, so the driver never latches a half-built frame.
module lcd_frame_sequencer #(
   parameter int REFRESH_DIV = 1048576,
   parameter int BLINK_TICKS = 8,
   parameter int MSG_TICKS   = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [87:0] time_frame,
   input  logic [87:0] set_frame,
   input  logic        set_active,
   input  logic [2:0]  set_field,
   input  logic [87:0] msg_frame,
   input  logic        msg_req,
   output logic [87:0] value,
   output logic [1:0]  src,
   output logic        msg_busy
);

   localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int HOLD_W = $clog2(MSG_TICKS + 1);

   localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MSG_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [87:0]       SPACES    = {11{8'h20}};

   typedef enum logic [1:0] {
      ST_TIME = 2'd0,
      ST_SET  = 2'd1,
      ST_MSG  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [REF_W-1:0]    r_refreshCnt;
   logic                w_tick;
   logic [HOLD_W-1:0]   r_msgHold;
   logic [HOLD_W-1:0]   w_msgHoldNext;
   logic [87:0]         r_msgFrame;
   logic [BLK_W-1:0]    r_blinkCnt;
   logic [BLK_W-1:0]    w_blinkCntNext;
   logic                r_blinkBlank;
   logic                w_blinkBlankNext;
   logic [2:0]          r_lastField;
   logic [87:0]         w_setMasked;
   logic [87:0]         w_frameSel;
   logic [87:0]         r_value;
   logic [1:0]          r_src;
   logic                r_msgBusy;

   assign w_tick = (r_refreshCnt == REF_LAST);

   // Free-running refresh divider; the tick marks its last count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_refreshCnt <= '0;
      end else if (w_tick) begin
         r_refreshCnt <= '0;
      end else begin
         r_refreshCnt <= r_refreshCnt + 1'b1;
      end
   end

   // Source arbitration: a message request overrides everything, and the
   // message hold only counts down on ticks that did not also load it
   always_comb begin
      w_nextState   = r_state;
      w_msgHoldNext = r_msgHold;
      if (msg_req) begin
         w_nextState   = ST_MSG;
         w_msgHoldNext = HOLD_LOAD;
      end else begin
         unique case (r_state)
            ST_TIME: begin
               if (set_active) begin
                  w_nextState = ST_SET;
               end
            end
            ST_SET: begin
               if (!set_active) begin
                  w_nextState = ST_TIME;
               end
            end
            ST_MSG: begin
               if (w_tick) begin
                  w_msgHoldNext = r_msgHold - 1'b1;
                  if (r_msgHold == HOLD_ONE) begin
                     w_nextState = set_active ? ST_SET : ST_TIME;
                  end
               end
            end
            default: begin
               w_nextState = ST_TIME;
            end
         endcase
      end
   end

   // State, hold counter and the registered source indicators move together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_TIME;
         r_msgHold <= '0;
         r_src     <= 2'd0;
         r_msgBusy <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_msgHold <= w_msgHoldNext;
         r_src     <= w_nextState;
         r_msgBusy <= (w_nextState == ST_MSG);
      end
   end

   // Latest requested message is held here until the next request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_msgFrame <= '0;
      end else if (msg_req) begin
         r_msgFrame <= msg_frame;
      end
   end

   // Blink timing only runs while staying in SET; entering SET, leaving it or
   // picking a new field restarts it in the visible phase
   always_comb begin
      w_blinkCntNext   = '0;
      w_blinkBlankNext = 1'b0;
      if ((r_state == ST_SET) && (w_nextState == ST_SET)) begin
         w_blinkCntNext   = r_blinkCnt;
         w_blinkBlankNext = r_blinkBlank;
         if (set_field != r_lastField) begin
            w_blinkCntNext   = '0;
            w_blinkBlankNext = 1'b0;
         end else if (w_tick) begin
            if (r_blinkCnt == BLK_LAST) begin
               w_blinkCntNext   = '0;
               w_blinkBlankNext = ~r_blinkBlank;
            end else begin
               w_blinkCntNext = r_blinkCnt + 1'b1;
            end
         end
      end
   end

   // Blink registers plus the previous field used for change detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blinkCnt   <= '0;
         r_blinkBlank <= 1'b0;
         r_lastField  <= 3'd0;
      end else begin
         r_blinkCnt   <= w_blinkCntNext;
         r_blinkBlank <= w_blinkBlankNext;
         r_lastField  <= set_field;
      end
   end

   // Set-mode frame with the edited field replaced by spaces in the blank phase
   always_comb begin
      w_setMasked = set_frame;
      if (r_blinkBlank) begin
         unique case (set_field)
            3'd1:    w_setMasked[79:64] = 16'h2020;
            3'd2:    w_setMasked[63:48] = 16'h2020;
            3'd3:    w_setMasked[47:32] = 16'h2020;
            3'd4:    w_setMasked[31:16] = 16'h2020;
            3'd5:    w_setMasked[15:0]  = 16'h2020;
            default: w_setMasked        = set_frame;
         endcase
      end
   end

   // Frame chosen by the state in force before any transition this cycle
   always_comb begin
      w_frameSel = time_frame;
      unique case (r_state)
         ST_TIME: w_frameSel = time_frame;
         ST_SET:  w_frameSel = w_setMasked;
         ST_MSG:  w_frameSel = r_msgFrame;
         default: w_frameSel = time_frame;
      endcase
   end

   // Output frame only changes on a refresh tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= SPACES;
      end else if (w_tick) begin
         r_value <= w_frameSel;
      end
   end

   assign value    = r_value;
   assign src      = r_src;
   assign msg_busy = r_msgBusy;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer: a tick-level reference model
// predicts value/src/msg_busy after every clock edge and a monitor compares.
module tb_lcd_frame_sequencer;

   localparam int REFRESH_DIV = 4;
   localparam int BLINK_TICKS = 2;
   localparam int MSG_TICKS   = 3;
   localparam logic [87:0] SPACES = {11{8'h20}};

   typedef struct {
      logic [87:0] value;
      logic [1:0]  src;
      logic        busy;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [87:0] time_frame;
   logic [87:0] set_frame;
   logic        set_active;
   logic [2:0]  set_field;
   logic [87:0] msg_frame;
   logic        msg_req;
   logic [87:0] value;
   logic [1:0]  src;
   logic        msg_busy;

   exp_t expQ[$];
   int   numChecks = 0;
   int   numPassed = 0;

   // Reference model state (plain ticks-and-modes view of the behaviour)
   int          mMode = 0;
   logic [87:0] mValue = SPACES;
   logic [87:0] mMsgFrame = '0;
   int          mMsgLeft = 0;
   int          mBlinkN = 0;
   logic [2:0]  mPrevField = 3'd0;
   int          mIdx = 0;

   lcd_frame_sequencer #(
      .REFRESH_DIV(REFRESH_DIV),
      .BLINK_TICKS(BLINK_TICKS),
      .MSG_TICKS  (MSG_TICKS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .time_frame(time_frame),
      .set_frame (set_frame),
      .set_active(set_active),
      .set_field (set_field),
      .msg_frame (msg_frame),
      .msg_req   (msg_req),
      .value     (value),
      .src       (src),
      .msg_busy  (msg_busy)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [87:0] rand88();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[87:0];
   endfunction

   function automatic logic [87:0] maskSet(input logic [87:0] f, input logic [2:0] field, input bit blank);
      logic [87:0] r;
      int hi;
      r = f;
      if (blank && field >= 3'd1 && field <= 3'd5) begin
         hi = 79 - 16 * (int'(field) - 1);
         r[hi -: 16] = 16'h2020;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input exp_t e);
      numChecks++;
      if (value === e.value && src === e.src && msg_busy === e.busy) begin
         numPassed++;
      end else begin
         $display("[TB] FAIL %s t=%0t value=%h src=%0d busy=%0b expected value=%h src=%0d busy=%0b",
                  name, $time, value, src, msg_busy, e.value, e.src, e.busy);
      end
   endtask

   // Reference model: on each edge, predict the outputs that edge produces
   always @(posedge clk) begin
      exp_t e;
      bit   tick;
      int   nextMode;
      if (rst) begin
         mMode = 0; mValue = SPACES; mMsgFrame = '0; mMsgLeft = 0;
         mBlinkN = 0; mPrevField = 3'd0; mIdx = 0;
      end else begin
         tick = ((mIdx % REFRESH_DIV) == REFRESH_DIV - 1);
         if (tick) begin
            case (mMode)
               0: mValue = time_frame;
               1: mValue = maskSet(set_frame, set_field, ((mBlinkN / BLINK_TICKS) % 2) == 1);
               default: mValue = mMsgFrame;
            endcase
         end
         nextMode = mMode;
         if (msg_req) begin
            nextMode = 2; mMsgLeft = MSG_TICKS; mMsgFrame = msg_frame;
         end else if (mMode == 0 && set_active) begin
            nextMode = 1;
         end else if (mMode == 1 && !set_active) begin
            nextMode = 0;
         end else if (mMode == 2 && tick) begin
            if (mMsgLeft == 1) nextMode = set_active ? 1 : 0;
            else mMsgLeft--;
         end
         if (mMode == 1 && nextMode == 1) begin
            if (set_field != mPrevField) mBlinkN = 0;
            else if (tick) mBlinkN++;
         end else begin
            mBlinkN = 0;
         end
         mPrevField = set_field;
         mMode = nextMode;
         mIdx++;
      end
      e.value = mValue;
      e.src   = 2'(mMode);
      e.busy  = (mMode == 2);
      expQ.push_back(e);
   end

   // Monitor: compare the DUT against the prediction just after each edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (expQ.size() == 0) begin
         numChecks++;
         $display("[TB] FAIL scoreboard_empty t=%0t value=%h src=%0d expected a queued prediction", $time, value, src);
      end else begin
         e = expQ.pop_front();
         checkOutput("cycle", e);
      end
   end

   // Asynchronous reset: outputs must clear with no clock edge
   task automatic pulseReset(input int holdCycles);
      exp_t e;
      rst = 1'b1;
      msg_req = 1'b0;
      #1;
      e.value = SPACES; e.src = 2'd0; e.busy = 1'b0;
      checkOutput("async_reset", e);
      repeat (holdCycles) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         msg_req = 1'b0;
      end
   endtask

   task automatic pulseMsg(input logic [87:0] f);
      msg_frame = f;
      msg_req = 1'b1;
      @(negedge clk);
      msg_req = 1'b0;
   endtask

   // Random cycle-by-cycle stimulus with occasional resets
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         msg_req = 1'b0;
         if ($urandom_range(0, 99) < 3) begin
            msg_req = 1'b1;
            msg_frame = rand88();
         end
         if ($urandom_range(0, 39) == 0) set_active = ~set_active;
         if ($urandom_range(0, 11) == 0) set_field = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) time_frame = rand88();
         if ($urandom_range(0, 7) == 0) set_frame = rand88();
         if ($urandom_range(0, 499) == 0) pulseReset(1);
      end
   endtask

   // Directed scenarios, then randomized traffic
   initial begin
      int guard;
      rst = 1'b1;
      time_frame = "12-31 23:59";
      set_frame = "ABCDEFG59HI";
      set_active = 1'b0;
      set_field = 3'd0;
      msg_frame = '0;
      msg_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released, idling");
      idle(8);

      set_field = 3'd4;
      set_active = 1'b1;
      idle(20);

      set_field = 3'd2;
      idle(6);
      set_field = 3'd4;
      idle(5);
      set_field = 3'd2;
      idle(14);

      guard = 0;
      while ((mIdx % REFRESH_DIV) != REFRESH_DIV - 1 && guard < 8) begin
         idle(1);
         guard++;
      end
      if (guard >= 8) begin
         numChecks++;
         $display("[TB] FAIL tick_align guard=%0d required below 8", guard);
      end
      pulseMsg("MSG ON TICK");
      idle(16);

      set_active = 1'b0;
      idle(3);
      pulseMsg("HELLO WORLD");
      idle(20);

      pulseMsg("FIRST MSG  ");
      idle(4);
      pulseMsg("SECOND MSG ");
      idle(20);

      pulseMsg("RESET SOON ");
      idle(5);
      pulseReset(2);
      idle(10);

      applyStimulus(1500);
      idle(2);
      $display("%0d/%0d checks passed", numPassed, numChecks);
      $finish;
   end

endmodule
